// File: rtl/reg_bank_initiator.sv
// Bus initiator for a bank of 16-bit register cells: sequences chip-select, write/read strobes
// and read capture for single or burst (1..4 beat) requests taken over a ready/valid handshake.
module reg_bank_initiator #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [1:0]          len,
    input  logic [15:0]         wdata,
    output logic                ready,
    output logic [15:0]         rdata,
    output logic                rvalid,
    output logic                done,
    output logic                err,
    output logic [15:0]         bus_d_in,
    output logic                bus_w,
    output logic                bus_r,
    output logic [NUM_REGS-1:0] cs,
    input  logic [15:0]         bus_d_out
);

    // One extra bit so NUM_REGS == 2**ADDR_W does not truncate to zero.
    localparam logic [ADDR_W:0]   NumRegsExt = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LastAddr   = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   beat_q, beat_d;
    logic [1:0]          remain_q, remain_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [15:0]         rdata_q;
    logic                rvalid_q;
    logic                in_range;
    logic                bus_active;
    logic                read_strobe;

    assign in_range    = {1'b0, addr} < NumRegsExt;
    assign read_strobe = (state_q == StStrobe) && !we_q;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        beat_d   = beat_q;
        remain_d = remain_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    we_d     = we;
                    wdata_d  = wdata;
                    beat_d   = addr;
                    remain_d = len;
                    err_d    = !in_range;
                    state_d  = in_range ? StSetup : StDone;
                end
            end
            StSetup: state_d = StStrobe;
            StStrobe: begin
                if (remain_q == 2'd0) begin
                    state_d = StDone;
                end else begin
                    remain_d = remain_q - 2'd1;
                    beat_d   = (beat_q == LastAddr) ? '0 : beat_q + 1'b1;
                    state_d  = StSetup;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            beat_q   <= '0;
            remain_q <= 2'd0;
            wdata_q  <= 16'h0;
            err_q    <= 1'b0;
            rdata_q  <= 16'h0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            beat_q   <= beat_d;
            remain_q <= remain_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rvalid_q <= read_strobe;
            if (read_strobe) begin
                rdata_q <= bus_d_out;
            end
        end
    end

    // Bus outputs decode from state and latched request only, so a reset drops them at once.
    assign bus_active = (state_q == StSetup) || (state_q == StStrobe);

    always_comb begin
        cs = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            cs[i] = bus_active && (beat_q == ADDR_W'(i));
        end
    end

    assign ready    = (state_q == StIdle);
    assign done     = (state_q == StDone);
    assign err      = (state_q == StDone) && err_q;
    assign bus_d_in = (bus_active && we_q) ? wdata_q : 16'h0;
    assign bus_w    = (state_q == StStrobe) && we_q;
    assign bus_r    = read_strobe;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;

endmodule

// File: tb/tb_reg_bank_initiator.sv
// Directed bench: two initiators (8 and 6 cells) driving behavioural register-cell banks.
module tb_reg_bank_initiator;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic cells_rdy;

    logic        req_a, we_a, ready_a, rvalid_a, done_a, err_a, w_a, r_a;
    logic [2:0]  addr_a;
    logic [1:0]  len_a;
    logic [15:0] wdata_a, rdata_a, d_in_a;
    logic [7:0]  cs_a;
    wire  [15:0] d_out_a;

    logic        req_b, we_b, ready_b, rvalid_b, done_b, err_b, w_b, r_b;
    logic [2:0]  addr_b;
    logic [1:0]  len_b;
    logic [15:0] wdata_b, rdata_b, d_in_b;
    logic [5:0]  cs_b;
    wire  [15:0] d_out_b;

    logic [15:0] mem_a [8];
    logic [15:0] mem_b [6];
    logic [15:0] rd_a, rd_b;

    reg_bank_initiator #(.NUM_REGS(8), .ADDR_W(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req_a), .we(we_a), .addr(addr_a), .len(len_a),
        .wdata(wdata_a), .ready(ready_a), .rdata(rdata_a), .rvalid(rvalid_a), .done(done_a),
        .err(err_a), .bus_d_in(d_in_a), .bus_w(w_a), .bus_r(r_a), .cs(cs_a),
        .bus_d_out(d_out_a)
    );

    reg_bank_initiator #(.NUM_REGS(6), .ADDR_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req_b), .we(we_b), .addr(addr_b), .len(len_b),
        .wdata(wdata_b), .ready(ready_b), .rdata(rdata_b), .rvalid(rvalid_b), .done(done_b),
        .err(err_b), .bus_d_in(d_in_b), .bus_w(w_b), .bus_r(r_b), .cs(cs_b),
        .bus_d_out(d_out_b)
    );

    always #5 clk = ~clk;

    // Register cells: write on the edge ending a write strobe, drive the shared bus while read.
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (!cells_rdy) mem_a[i] <= 16'h0;
            else if (cs_a[i] && w_a) mem_a[i] <= d_in_a;
        end
        for (int i = 0; i < 6; i++) begin
            if (!cells_rdy) mem_b[i] <= 16'h0;
            else if (cs_b[i] && w_b) mem_b[i] <= d_in_b;
        end
    end

    always_comb begin
        rd_a = 16'h0;
        rd_b = 16'h0;
        for (int i = 0; i < 8; i++) if (cs_a[i]) rd_a = mem_a[i];
        for (int i = 0; i < 6; i++) if (cs_b[i]) rd_b = mem_b[i];
    end

    assign d_out_a = r_a ? rd_a : 16'hzzzz;
    assign d_out_b = r_b ? rd_b : 16'hzzzz;

    // Returns at the negedge inside cycle 1 (the cycle after the accepting edge).
    task automatic start_a(input logic w, input logic [2:0] a, input logic [1:0] l,
                           input logic [15:0] d);
        @(negedge clk);
        req_a = 1'b1; we_a = w; addr_a = a; len_a = l; wdata_a = d;
        @(posedge clk);
        @(negedge clk);
        req_a = 1'b0;
    endtask

    task automatic start_b(input logic w, input logic [2:0] a, input logic [1:0] l,
                           input logic [15:0] d);
        @(negedge clk);
        req_b = 1'b1; we_b = w; addr_b = a; len_b = l; wdata_b = d;
        @(posedge clk);
        @(negedge clk);
        req_b = 1'b0;
    endtask

    task automatic test_reset;
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd1; len_a = 2'd0; wdata_a = 16'hFFFF;
        req_b = 1'b1; we_b = 1'b1; addr_b = 3'd1; len_b = 2'd0; wdata_b = 16'hFFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            cells_rdy = 1'b1;
            checks++;
            if ({ready_a, cs_a, w_a, r_a, done_a, rdata_a, ready_b, cs_b} !==
                {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 6'h00}) begin
                errors++;
                $display("FAIL reset_hold: got %h want %h",
                         {ready_a, cs_a, w_a, r_a, done_a, rdata_a, ready_b, cs_b},
                         {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 6'h00});
            end
        end
        rst_n = 1'b1; req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready_a, cs_a, ready_b} !== {1'b1, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", {ready_a, cs_a, ready_b},
                     {1'b1, 8'h00, 1'b1});
        end
    endtask

    task automatic test_single;
        start_a(1'b1, 3'd5, 2'd0, 16'hA5C3);
        checks++;
        if ({cs_a, w_a, r_a, d_in_a} !== {8'h20, 1'b0, 1'b0, 16'hA5C3}) begin
            errors++;
            $display("FAIL wr_setup: got %h want %h", {cs_a, w_a, r_a, d_in_a},
                     {8'h20, 1'b0, 1'b0, 16'hA5C3});
        end
        @(negedge clk);
        checks++;
        if ({cs_a, w_a, r_a} !== {8'h20, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wr_strobe: got %h want %h", {cs_a, w_a, r_a}, {8'h20, 1'b1, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({done_a, err_a, cs_a, w_a, ready_a} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wr_done: got %h want %h", {done_a, err_a, cs_a, w_a, ready_a},
                     {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({ready_a, done_a, mem_a[5]} !== {1'b1, 1'b0, 16'hA5C3}) begin
            errors++;
            $display("FAIL wr_idle_cell: got %h want %h", {ready_a, done_a, mem_a[5]},
                     {1'b1, 1'b0, 16'hA5C3});
        end
        start_a(1'b0, 3'd5, 2'd0, 16'h0);
        checks++;
        if ({cs_a, r_a, d_in_a} !== {8'h20, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL rd_setup: got %h want %h", {cs_a, r_a, d_in_a}, {8'h20, 1'b0, 16'h0});
        end
        @(negedge clk);
        checks++;
        if ({cs_a, r_a, w_a} !== {8'h20, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rd_strobe: got %h want %h", {cs_a, r_a, w_a}, {8'h20, 1'b1, 1'b0});
        end
        @(negedge clk);
        checks++;
        if ({done_a, rvalid_a, rdata_a} !== {1'b1, 1'b1, 16'hA5C3}) begin
            errors++;
            $display("FAIL rd_data: got %h want %h", {done_a, rvalid_a, rdata_a},
                     {1'b1, 1'b1, 16'hA5C3});
        end
        @(negedge clk);
    endtask

    task automatic test_burst_wrap;
        logic [2:0] seq [4];
        logic [7:0] exp_cs;
        logic       exp_rv;
        int         wcount;
        int         first_done;
        seq[0] = 3'd6; seq[1] = 3'd7; seq[2] = 3'd0; seq[3] = 3'd1;
        wcount = 0;
        first_done = 0;
        start_a(1'b1, 3'd6, 2'd3, 16'h0F0F);
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) @(negedge clk);
            if (w_a) wcount++;
            if (done_a && first_done == 0) first_done = c;
            if (c <= 8) begin
                exp_cs = 8'd1 << seq[(c - 1) / 2];
                checks++;
                if (cs_a !== exp_cs) begin
                    errors++;
                    $display("FAIL burst_cs cycle %0d: got %h want %h", c, cs_a, exp_cs);
                end
            end
        end
        checks++;
        if (wcount != 4 || first_done != 9) begin
            errors++;
            $display("FAIL burst_w_done: got w=%0d done@%0d want w=4 done@9", wcount, first_done);
        end
        checks++;
        if ({mem_a[6], mem_a[7], mem_a[0], mem_a[1], mem_a[2], mem_a[5]} !==
            {16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0000, 16'hA5C3}) begin
            errors++;
            $display("FAIL burst_cells: got %h want %h",
                     {mem_a[6], mem_a[7], mem_a[0], mem_a[1], mem_a[2], mem_a[5]},
                     {16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0000, 16'hA5C3});
        end
        start_a(1'b0, 3'd6, 2'd3, 16'h0);
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) @(negedge clk);
            exp_rv = (c >= 3) && (c % 2 == 1);
            checks++;
            if (rvalid_a !== exp_rv || (exp_rv && rdata_a !== 16'h0F0F)) begin
                errors++;
                $display("FAIL burst_rd cycle %0d: got rv=%b d=%h want rv=%b d=0f0f",
                         c, rvalid_a, rdata_a, exp_rv);
            end
        end
        checks++;
        if (done_a !== 1'b1) begin
            errors++;
            $display("FAIL burst_rd_done: got %b want 1", done_a);
        end
        @(negedge clk);
    endtask

    task automatic test_out_of_range;
        logic [5:0] exp_cs;
        start_b(1'b1, 3'd5, 2'd1, 16'h1234);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge clk);
            exp_cs = (c <= 2) ? 6'b100000 : 6'b000001;
            checks++;
            if (cs_b !== exp_cs) begin
                errors++;
                $display("FAIL wrap6_cs cycle %0d: got %b want %b", c, cs_b, exp_cs);
            end
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({mem_b[5], mem_b[0]} !== {16'h1234, 16'h1234}) begin
            errors++;
            $display("FAIL wrap6_cells: got %h want %h", {mem_b[5], mem_b[0]},
                     {16'h1234, 16'h1234});
        end
        start_b(1'b0, 3'd0, 2'd0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rvalid_b, rdata_b} !== {1'b1, 16'h1234}) begin
            errors++;
            $display("FAIL wrap6_rd: got %h want %h", {rvalid_b, rdata_b}, {1'b1, 16'h1234});
        end
        for (int k = 0; k < 2; k++) begin
            start_b(1'b0, (k == 0) ? 3'd7 : 3'd6, 2'd0, 16'h0);
            checks++;
            if ({done_b, err_b, cs_b, r_b, w_b, rvalid_b, rdata_b} !==
                {1'b1, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 16'h1234}) begin
                errors++;
                $display("FAIL oor_c1 addr %0d: got %h want %h", 7 - k,
                         {done_b, err_b, cs_b, r_b, w_b, rvalid_b, rdata_b},
                         {1'b1, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 16'h1234});
            end
            @(negedge clk);
            checks++;
            if ({ready_b, done_b, err_b, cs_b, r_b, rdata_b} !==
                {1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 16'h1234}) begin
                errors++;
                $display("FAIL oor_c2 addr %0d: got %h want %h", 7 - k,
                         {ready_b, done_b, err_b, cs_b, r_b, rdata_b},
                         {1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 16'h1234});
            end
        end
    endtask

    task automatic test_busy_ignore;
        logic [7:0] exp_cs;
        int         rcount;
        int         got_done;
        rcount = 0;
        got_done = 0;
        @(negedge clk);
        req_a = 1'b1; we_a = 1'b0; addr_a = 3'd2; len_a = 2'd1;
        @(posedge clk);
        @(negedge clk);
        addr_a = 3'd4;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            if (r_a) rcount++;
            exp_cs = (c <= 2) ? 8'h04 : (c <= 4) ? 8'h08 : 8'h00;
            checks++;
            if ({ready_a, cs_a, done_a} !== {1'b0, exp_cs, c == 5}) begin
                errors++;
                $display("FAIL busy cycle %0d: got %h want %h", c, {ready_a, cs_a, done_a},
                         {1'b0, exp_cs, c == 5});
            end
        end
        checks++;
        if (rcount != 2) begin
            errors++;
            $display("FAIL busy_strobes: got %0d want 2", rcount);
        end
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b1) begin
            errors++;
            $display("FAIL busy_ready: got %b want 1", ready_a);
        end
        @(negedge clk);
        req_a = 1'b0;
        checks++;
        if ({ready_a, cs_a} !== {1'b0, 8'h10}) begin
            errors++;
            $display("FAIL busy_second: got %h want %h", {ready_a, cs_a}, {1'b0, 8'h10});
        end
        for (int c = 0; c < 10 && got_done == 0; c++) begin
            @(negedge clk);
            if (done_a) got_done = 1;
        end
        checks++;
        if (got_done != 1) begin
            errors++;
            $display("FAIL busy_second_done: got %0d want 1", got_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int done_seen;
        done_seen = 0;
        start_a(1'b1, 3'd2, 2'd3, 16'hBEEF);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({w_a, cs_a} !== {1'b1, 8'h08}) begin
            errors++;
            $display("FAIL mid_strobe: got %h want %h", {w_a, cs_a}, {1'b1, 8'h08});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({w_a, cs_a, ready_a, done_a} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL mid_drop: got %h want %h", {w_a, cs_a, ready_a, done_a},
                     {1'b0, 8'h00, 1'b1, 1'b0});
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 1) rst_n = 1'b1;
            if (done_a) done_seen++;
        end
        checks++;
        if (done_seen != 0 || {mem_a[2], mem_a[3], mem_a[4]} !== {16'hBEEF, 16'h0, 16'h0}) begin
            errors++;
            $display("FAIL mid_after: got done=%0d cells=%h want done=0 cells=%h", done_seen,
                     {mem_a[2], mem_a[3], mem_a[4]}, {16'hBEEF, 16'h0, 16'h0});
        end
        start_a(1'b0, 3'd2, 2'd0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rvalid_a, rdata_a} !== {1'b1, 16'hBEEF}) begin
            errors++;
            $display("FAIL mid_rd_beat1: got %h want %h", {rvalid_a, rdata_a}, {1'b1, 16'hBEEF});
        end
        start_a(1'b0, 3'd4, 2'd0, 16'h0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({rvalid_a, done_a, rdata_a} !== {1'b1, 1'b1, 16'h0}) begin
            errors++;
            $display("FAIL mid_rd_beat3: got %h want %h", {rvalid_a, done_a, rdata_a},
                     {1'b1, 1'b1, 16'h0});
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        cells_rdy = 1'b0;
        checks = 0;
        errors = 0;
        req_a = 1'b0; we_a = 1'b0; addr_a = 3'd0; len_a = 2'd0; wdata_a = 16'h0;
        req_b = 1'b0; we_b = 1'b0; addr_b = 3'd0; len_b = 2'd0; wdata_b = 16'h0;
        test_reset();
        test_single();
        test_burst_wrap();
        test_out_of_range();
        test_busy_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_initiator.md
# reg_bank_initiator

Bus initiator that drives a bank of 16-bit register cells through their write, read and chip-select pins. Each cell has a shared 16-bit write-data bus, shared w/r strobes, one chip-select per cell and a shared tri-state read-data bus. The block accepts single or burst read/write requests from a requester over a ready/valid handshake. It sequences chip-select and strobes with a setup cycle per beat, captures read data, and reports completion and address errors.

## Interface
- NUM_REGS, 8, number of register cells on the bus (2..2^ADDR_W)
- ADDR_W, 3, width of the register address
- clk  input  1  rising-edge clock, shared with the register cells
- rst_n  input  1  asynchronous active-low reset
- req  input  1  request valid; accepted when req && ready at a rising edge
- we  input  1  1 = write, 0 = read; sampled at accept
- addr  input  ADDR_W  start address; sampled at accept
- len  input  2  beats minus one (1..4 beats); sampled at accept
- wdata  input  16  write value; sampled at accept, written to every beat (fill)
- ready  output  1  high only in IDLE
- rdata  output  16  last captured read word
- rvalid  output  1  one-cycle pulse per captured read beat
- done  output  1  one-cycle pulse at end of request
- err  output  1  valid with done; 1 = request rejected for address range
- bus_d_in  output  16  data to cell d_in
- bus_w  output  1  write strobe to all cells
- bus_r  output  1  read strobe to all cells
- cs  output  NUM_REGS  one-hot chip-select
- bus_d_out  input  16  shared read bus from cells, Z when no cell is reading

## Operation
- States: IDLE, SETUP, STROBE, DONE.
- IDLE: ready=1, all bus outputs 0. On accept, latch we, addr, len, wdata.
  - If addr >= NUM_REGS, go to DONE with err=1. No cs or strobe is ever asserted.
  - Otherwise, set beat address = addr and remaining = len, then go to SETUP.
- SETUP: cs[beat address]=1. bus_d_in=wdata on writes, 0 on reads. bus_w=bus_r=0. Next state is STROBE.
- STROBE: cs and bus_d_in held. bus_w=1 on writes, bus_r=1 on reads.
  - On a read, bus_d_out is registered into rdata at the edge ending STROBE, and rvalid=1 in the following cycle.
  - If remaining=0, go to DONE. Otherwise decrement remaining, increment beat address modulo NUM_REGS (NUM_REGS-1 wraps to 0), and go to SETUP.
- DONE: done=1, err as latched, all bus outputs 0. Next state is IDLE.
- req while ready=0 is ignored and not queued.
- Exactly one cs bit is high in SETUP/STROBE; cs is all-zero elsewhere.
- bus_w and bus_r are never both high.
- bus_d_out is sampled only at the end of a read STROBE. Z/X at any other time is ignored.
- Burst wrap is checked only on the start address. Wrapped beat addresses are always in range.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - ready=1, and rdata, rvalid, done, err, bus_d_in, bus_w, bus_r, cs all = 0.
  - An in-flight burst is abandoned. A strobe deasserts mid-cycle; no partial result is reported.
- Accept at edge E0 (req && ready):
  - SETUP occupies cycle 1, STROBE cycle 2.
  - The cell writes at the edge ending cycle 2.
- Latency by request type:
  - Single beat: done in cycle 3, ready=1 in cycle 4. A new accept is possible at the edge ending cycle 4.
  - N beats: 2N bus cycles, then DONE. Total 2N+1 cycles from accept to done.
- Reads: rvalid for beat k appears in the cycle after that beat's STROBE. This is the next SETUP or DONE. The last rvalid coincides with done.
- Out-of-range request: done=1, err=1 in cycle 1; ready in cycle 2.
- All outputs are registered or decoded from state only. There is no combinational path from req, addr or bus_d_out to any output.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req=1, then release. Required: ready=1, cs=0, bus_w=bus_r=0, done=0, rdata=0 throughout; nothing is accepted until after release.
- Single write then read (NUM_REGS=8): write addr=5, wdata=16'hA5C3, len=0. Required: cs=8'b0010_0000 for 2 cycles, bus_w only in cycle 2, done in cycle 3. Read addr=5 afterwards. Required: rdata=16'hA5C3 with rvalid and done in the same cycle.
- Burst fill with wrap: write addr=6, len=3, wdata=16'h0F0F. Required: cs sequence 6,7,0,1, 4 bus_w pulses, done 9 cycles after accept. A 4-beat read from addr=6 returns 4 rvalid pulses, each with 16'h0F0F.
- Out-of-range (NUM_REGS=6): read addr=7. Required: cs=0 and bus_r=0 at all times, done=err=1 in cycle 1, rdata unchanged.
- Busy ignore: issue a 2-beat read and hold req=1 with a different addr throughout. Required: exactly one request is serviced, and a second accept occurs only in the cycle after done.
- Reset mid-burst: assert rst_n=0 during the STROBE of beat 2 of a 4-beat write. Required: bus_w and cs drop immediately, no done is produced, and after release a read of beat 3's address shows it was not written.
